// File: rtl/timer_device_pkg.sv
// Shared definitions for the memory-mapped countdown timer: register map,
// CTRL field layout, mode encodings and FSM states.
package timer_device_pkg;

    localparam logic [15:0] TIMER0_BASE = 16'h7F00;
    localparam logic [15:0] TIMER1_BASE = 16'h7F10;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_IM_BIT   = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    // Field order matches CTRL[3:0]: IM, MODE[1:0], EN.
    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

endpackage

// File: rtl/timer_device.sv
// Countdown timer device: CTRL/PRESET/COUNT register file, count FSM,
// combinational read mux and level interrupt.
module timer_device
    import timer_device_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    ctrl_t               ctrl_q, ctrl_d;
    logic [COUNT_W-1:0]  preset_q, preset_d;
    logic [COUNT_W-1:0]  count_q, count_d;
    logic                irq_flag_q, irq_flag_d;
    state_t              state_q, state_d;

    logic wr_ctrl, wr_preset, reload_mode;

    assign wr_ctrl     = we && (addr == REG_CTRL);
    assign wr_preset   = we && (addr == REG_PRESET);
    assign reload_mode = (ctrl_q.mode == MODE_RELOAD);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        preset_d   = preset_q;
        ctrl_d     = ctrl_q;
        irq_flag_d = irq_flag_q;

        unique case (state_q)
            ST_IDLE: if (ctrl_q.en) state_d = ST_LOAD;
            ST_LOAD: begin
                irq_flag_d = 1'b0;
                if (!ctrl_q.en) begin
                    state_d = ST_IDLE;
                end else begin
                    count_d = preset_q;
                    state_d = ST_CNT;
                end
            end
            ST_CNT: begin
                if (!ctrl_q.en)          state_d = ST_IDLE;
                else if (count_q == '0)  state_d = ST_INT;
                else                     count_d = count_q - {{(COUNT_W-1){1'b0}}, 1'b1};
            end
            ST_INT: begin
                if (ctrl_q.en && reload_mode) begin
                    state_d = ST_LOAD;
                end else begin
                    ctrl_d.en = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Bus writes override the hardware EN clear; a flag set in INT
        // overrides the write-side clear.
        if (wr_ctrl)   ctrl_d   = ctrl_t'(wdata[3:0]);
        if (wr_preset) preset_d = wdata[COUNT_W-1:0];
        if (wr_ctrl || wr_preset) irq_flag_d = 1'b0;
        if (state_q == ST_INT)    irq_flag_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    always_comb begin
        rdata = '0;
        unique case (addr)
            REG_CTRL:   rdata = {28'b0, ctrl_q};
            REG_PRESET: rdata = 32'(preset_q);
            REG_COUNT:  rdata = 32'(count_q);
            REG_RSVD:   rdata = '0;
            default:    rdata = '0;
        endcase
    end

    assign irq = ctrl_q.im & irq_flag_q;

endmodule

// File: tb/tb_timer_device.sv
// Directed bench for timer_device: register access, one-shot and reload
// timing, masking, preset rewrite, reset and simultaneous-event cases.
module tb_timer_device;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  addr = '0;
    logic        we = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq;

    int tests = 0;
    int fails = 0;

    timer_device #(.COUNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .we(we),
        .wdata(wdata), .rdata(rdata), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we    = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        tests++;
        assert (rdata === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, rdata, exp);
        end
    endtask

    task automatic irq_chk(input string tag, input logic exp);
        tests++;
        assert (irq === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, irq, exp);
        end
    endtask

    initial begin
        // Reset state
        #12 rst_n = 1'b1;
        step();
        rd_chk("rst_ctrl", 2'd0, 32'h0);
        rd_chk("rst_count", 2'd2, 32'h0);
        irq_chk("rst_irq", 1'b0);

        // 1. Reset mid-count
        wr(2'd1, 32'd100);
        wr(2'd0, 32'h1);
        for (int i = 0; i < 52; i++) step();
        rd_chk("t1_count50", 2'd2, 32'd50);
        #2 rst_n = 1'b0;
        rd_chk("t1_async_ctrl", 2'd0, 32'h0);
        rd_chk("t1_async_preset", 2'd1, 32'h0);
        rd_chk("t1_async_count", 2'd2, 32'h0);
        irq_chk("t1_async_irq", 1'b0);
        step();
        #3 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        rd_chk("t1_post_count", 2'd2, 32'h0);
        rd_chk("t1_post_ctrl", 2'd0, 32'h0);

        // 2. One-shot, PRESET=3: irq 7 edges after the CTRL write
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h9);
        step();
        step(); rd_chk("t2_c3", 2'd2, 32'd3);
        step(); rd_chk("t2_c2", 2'd2, 32'd2);
        step(); rd_chk("t2_c1", 2'd2, 32'd1);
        step(); rd_chk("t2_c0", 2'd2, 32'd0); irq_chk("t2_irq_e5", 1'b0);
        step(); irq_chk("t2_irq_e6", 1'b0);
        step(); irq_chk("t2_irq_e7", 1'b1);
        rd_chk("t2_ctrl_en_clr", 2'd0, 32'h8);
        wr(2'd1, 32'd5);
        irq_chk("t2_irq_clr", 1'b0);

        // 3. Auto-reload, PRESET=2: pulses at edges 6,11,16,21
        wr(2'd1, 32'd2);
        wr(2'd0, 32'hB);
        for (int k = 1; k <= 22; k++) begin
            step();
            irq_chk($sformatf("t3_pulse_e%0d", k), (k >= 6) && ((k - 6) % 5 == 0));
        end
        wr(2'd0, 32'hA);
        step();
        rd_chk("t3_frozen_a", 2'd2, 32'd1);
        for (int k = 0; k < 10; k++) step();
        irq_chk("t3_no_pulse", 1'b0);
        rd_chk("t3_frozen_b", 2'd2, 32'd1);

        // 4. Masking
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h1);
        for (int k = 0; k < 6; k++) step();
        irq_chk("t4_masked", 1'b0);
        rd_chk("t4_expired", 2'd0, 32'h0);
        wr(2'd0, 32'h8);
        irq_chk("t4_flag_cleared", 1'b0);

        // 5. Mid-count PRESET rewrite, auto-reload
        wr(2'd1, 32'd10);
        wr(2'd0, 32'hB);
        for (int k = 0; k < 5; k++) step();
        wr(2'd1, 32'd2);
        rd_chk("t5_cont6", 2'd2, 32'd6);
        step(); rd_chk("t5_cont5", 2'd2, 32'd5);
        for (int k = 0; k < 7; k++) step();
        rd_chk("t5_at0", 2'd2, 32'd0);
        irq_chk("t5_irq_e14", 1'b1);
        step();
        rd_chk("t5_reload2", 2'd2, 32'd2);
        irq_chk("t5_irq_e15", 1'b0);
        wr(2'd0, 32'h0);
        step();

        // 6. Ignored accesses
        rd_chk("t6_count_pre", 2'd2, 32'd1);
        wr(2'd2, 32'hFFFF);
        rd_chk("t6_count_a2", 2'd2, 32'd1);
        wr(2'd3, 32'hFFFF);
        rd_chk("t6_count_a3", 2'd2, 32'd1);
        rd_chk("t6_rsvd", 2'd3, 32'h0);
        rd_chk("t6_preset", 2'd1, 32'd2);
        wr(2'd0, 32'hFFFF_FFF1);
        rd_chk("t6_ctrl_mask", 2'd0, 32'h1);
        wr(2'd0, 32'h0);
        step();

        // 7. PRESET=0, then CTRL write landing in the INT cycle
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        for (int k = 0; k < 3; k++) step();
        irq_chk("t7_p0_e3", 1'b0);
        step();
        irq_chk("t7_p0_e4", 1'b1);
        wr(2'd0, 32'h0);
        wr(2'd0, 32'h9);
        for (int k = 0; k < 3; k++) step();
        wr(2'd0, 32'hB);
        rd_chk("t7_ctrl_wins", 2'd0, 32'hB);
        irq_chk("t7_flag_wins", 1'b1);
        wr(2'd0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
